// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide execute unit with start/done handshake and flush.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_w_addr_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_flag_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_w_addr_o,
  output logic            reg_w_ena_o
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  acc_hi, acc_lo, opb_q;
  logic             neg_res, neg_rem;

  logic             accept, is_div_in, op1_signed, op2_signed, s1, s2;
  logic [XLEN-1:0]  abs1, abs2;
  logic             div_zero, div_ovf, special, fast_mul;
  logic [XLEN-1:0]  special_result;

  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_shift;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_result;

  // Operand decode at the accept point: signedness, magnitudes and divide corner cases
  always_comb begin
    is_div_in  = op_i[2];
    op1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    op2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    s1   = op1_signed & op1_i[XLEN-1];
    s2   = op2_signed & op2_i[XLEN-1];
    abs1 = s1 ? -op1_i : op1_i;
    abs2 = s2 ? -op2_i : op2_i;
    div_zero = is_div_in && (op2_i == '0);
    div_ovf  = is_div_in && !op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_result = op_i[1] ? op1_i : '1;
    else
      special_result = op_i[1] ? '0 : op1_i;
    accept = (state == IDLE) && start_i && !flush_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_result;

  // Sign-extending to 2*XLEN makes a plain truncated multiply exact for every MUL* flavour
  always_comb begin
    fast_a      = {{XLEN{s1 & op1_i[XLEN-1]}}, op1_i};
    fast_b      = {{XLEN{s2 & op2_i[XLEN-1]}}, op2_i};
    fast_prod   = fast_a * fast_b;
    fast_result = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    fast_mul    = !op_i[2];
  end
`else
  assign fast_mul = 1'b0;
`endif

  // One shift-add or restoring-division step on the shared {acc_hi, acc_lo} pair
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_ge    = {acc_hi, acc_lo[XLEN-1]} >= {1'b0, opb_q};
    div_shift = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    if (op_q[2]) begin
      step_hi = div_ge ? (div_shift - opb_q) : div_shift;
      step_lo = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod_raw = {step_hi, step_lo};
    prod_fix = neg_res ? -prod_raw : prod_raw;
    quot_fix = neg_res ? -step_lo : step_lo;
    rem_fix  = neg_rem ? -step_hi : step_hi;
    if (op_q[2])
      final_result = op_q[1] ? rem_fix : quot_fix;
    else
      final_result = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opb_q        <= '0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      result_o     <= '0;
      reg_w_addr_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          op_q         <= op_i;
          acc_hi       <= '0;
          acc_lo       <= abs1;
          opb_q        <= abs2;
          neg_res      <= s1 ^ s2;
          neg_rem      <= s1;
          cnt          <= CNT_W'(XLEN);
          reg_w_addr_o <= reg_w_addr_i;
          if (special) result_o <= special_result;
`ifdef MULDIV_FAST_MUL_EN
          else if (fast_mul) result_o <= fast_result;
`endif
        end
        CALC: if (!flush_i) begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) result_o <= final_result;
        end
        default: ;
      endcase
    end
  end

  // Stall covers the accept cycle and CALC so the issuing stage holds its operands
  always_comb begin
    state_next     = state;
    ready_o        = 1'b0;
    stall_flag_o   = 1'b0;
    result_valid_o = 1'b0;
    reg_w_ena_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          stall_flag_o = 1'b1;
          state_next   = (special || fast_mul) ? DONE : CALC;
        end
      end
      CALC: begin
        stall_flag_o = 1'b1;
        if (flush_i)
          state_next = IDLE;
        else if (cnt == CNT_W'(1))
          state_next = DONE;
      end
      DONE: begin
        result_valid_o = !flush_i;
        reg_w_ena_o    = !flush_i;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
